// File: rtl/ysyx_22041207_dmem_responder.sv
// Data-memory responder: word-addressed 64-bit RAM behind valid/ready request and response channels.
// Define DMEM_BOUND_CHECK_EN to flag (and suppress) accesses outside [BASE, BASE+8*DEPTH).
module ysyx_22041207_dmem_responder #(
  parameter int          DEPTH       = 4096,
  parameter logic [63:0] BASE        = 64'h8000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDXW      = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, stateNext;
  logic [3:0]        waitCnt;
  logic              latWen;
  logic [IDXW-1:0]   latIdx;
  logic [63:0]       latWdata;
  logic [7:0]        latWmask;
  logic              latErr;
  logic              respValidQ;
  logic [63:0]       respRdataQ;
  logic              respErrQ;
  logic [63:0]       mem [DEPTH];

  logic [63:0]       addrOff;
  logic              reqErr;
  logic              accept;
  logic              ramAccess;
  logic              handshake;
  logic              unusedAddrBits;

  assign addrOff        = req_addr - BASE;
  assign unusedAddrBits = ^addrOff;
  assign accept         = req_valid & req_ready;
  // The RAM is touched exactly once, in the first RESP cycle, before resp_valid rises.
  assign ramAccess      = (state == S_RESP) && !respValidQ;
  assign handshake      = respValidQ & resp_ready;

`ifdef DMEM_BOUND_CHECK_EN
  // Addresses below BASE wrap to huge offsets, so one unsigned compare covers both ends.
  assign reqErr = (addrOff >= (64'(DEPTH) * 64'd8));
`else
  assign reqErr = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= stateNext;
  end

  // NOTE: default assignment first so no path through the case leaves stateNext unassigned (no latch).
  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE: if (accept) stateNext = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (waitCnt == 4'd0) stateNext = S_RESP;
      S_RESP: if (handshake) stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = respValidQ;
    resp_rdata = respRdataQ;
    resp_err   = respErrQ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt    <= 4'd0;
      latWen     <= 1'b0;
      latIdx     <= '0;
      latWdata   <= 64'd0;
      latWmask   <= 8'd0;
      latErr     <= 1'b0;
      respValidQ <= 1'b0;
      respRdataQ <= 64'd0;
      respErrQ   <= 1'b0;
    end else begin
      if (accept) begin
        latWen   <= req_wen;
        latIdx   <= addrOff[IDXW+2:3];
        latWdata <= req_wdata;
        latWmask <= req_wmask;
        latErr   <= reqErr;
        waitCnt  <= WAIT_LOAD;
      end else if (state == S_WAIT && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end

      if (ramAccess) begin
        respValidQ <= 1'b1;
        respRdataQ <= (latWen || latErr) ? 64'd0 : mem[latIdx];
        respErrQ   <= latErr;
      end else if (handshake) begin
        respValidQ <= 1'b0;
      end
    end
  end

  // NOTE: RAM contents are deliberately not reset; only the control path above is.
  always_ff @(posedge clk) begin
    if (!rst && ramAccess && latWen && !latErr) begin
      for (int i = 0; i < 8; i++) begin
        if (latWmask[i]) mem[latIdx][8*i +: 8] <= latWdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_dmem_responder.sv
// Self-checking bench for ysyx_22041207_dmem_responder: directed vector table, corner sequences,
// and randomized traffic against a byte-lane memory model.
module tb_ysyx_22041207_dmem_responder;

  localparam int          W     = 2;
  localparam int          DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  ysyx_22041207_dmem_responder #(
    .DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] expRdata;
    logic        expErr;
  } vec_t;

  int vectors    = 0;
  int mismatches = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      mismatches++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full request/response transaction; hold = cycles resp_ready stays low once resp_valid is up.
  task automatic doTxn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, input int hold, input string tag,
                       output logic [63:0] rdata, output logic err);
    int lat;
    check({tag, " req_ready before"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    @(posedge clk); #1;
    // Keep presenting a garbage store while busy: it must be ignored.
    req_wen = 1'b1; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom}; req_wmask = 8'hFF;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      check({tag, " req_ready busy"}, 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(W + 1));
    rdata = resp_rdata;
    err   = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 64'(resp_valid), 64'd1);
      check({tag, " hold rdata"}, resp_rdata, rdata);
      check({tag, " hold err"}, 64'(resp_err), 64'(err));
      check({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, " valid after hs"}, 64'(resp_valid), 64'd0);
    check({tag, " req_ready after hs"}, 64'(req_ready), 64'd1);
  endtask

  function automatic logic [63:0] mergeBytes(input logic [63:0] old, input logic [63:0] wdata,
                                             input logic [7:0] wmask);
    logic [63:0] m;
    m = 64'd0;
    for (int b = 0; b < 8; b++) if (wmask[b]) m |= 64'hFF << (8 * b);
    return (old & ~m) | (wdata & m);
  endfunction

  vec_t        vecs [14];
  logic [63:0] model [16];
  logic [63:0] rd;
  logic        er;

  initial begin
    // Directed vectors; the last four differ with the bound check enabled.
    vecs[0]  = '{1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 64'd0, 1'b0};
    vecs[1]  = '{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{1'b1, 64'h8000_0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'd0, 1'b0};
    vecs[3]  = '{1'b0, 64'h8000_0017, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vecs[4]  = '{1'b1, 64'h8000_0010, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'd0, 1'b0};
    vecs[5]  = '{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vecs[6]  = '{1'b1, 64'h8000_0000, 64'h0123456789ABCDEF, 8'hFF, 64'd0, 1'b0};
    vecs[7]  = '{1'b1, 64'h8000_7FF8, 64'd0, 8'hFF, 64'd0, 1'b0};
    vecs[8]  = '{1'b1, 64'h8000_7FF8, 64'hDEADBEEFCAFEF00D, 8'h81, 64'd0, 1'b0};
    vecs[9]  = '{1'b0, 64'h8000_7FF8, 64'd0, 8'h00, 64'hDE0000000000000D, 1'b0};
`ifdef DMEM_BOUND_CHECK_EN
    vecs[10] = '{1'b0, 64'h8000_8000, 64'd0, 8'h00, 64'd0, 1'b1};
    vecs[11] = '{1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1};
    vecs[12] = '{1'b1, 64'h8000_8000, 64'h5555555555555555, 8'hFF, 64'd0, 1'b1};
    vecs[13] = '{1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
`else
    vecs[10] = '{1'b0, 64'h8000_8000, 64'd0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
    vecs[11] = '{1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'hDE0000000000000D, 1'b0};
    vecs[12] = '{1'b1, 64'h8000_8000, 64'h5555555555555555, 8'hFF, 64'd0, 1'b0};
    vecs[13] = '{1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h5555555555555555, 1'b0};
`endif

    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0;
    req_wdata = 64'd0; req_wmask = 8'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset resp_rdata", resp_rdata, 64'd0);
    check("reset resp_err", 64'(resp_err), 64'd0);
    @(posedge clk); #1;
    check("idle req_ready", 64'(req_ready), 64'd1);
    check("idle resp_valid", 64'(resp_valid), 64'd0);

    for (int v = 0; v < 14; v++) begin
      doTxn(vecs[v].wen, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, v % 3,
            $sformatf("vec%0d", v), rd, er);
      check($sformatf("vec%0d rdata", v), rd, vecs[v].expRdata);
      check($sformatf("vec%0d err", v), 64'(er), 64'(vecs[v].expErr));
    end

    // Back-pressure: response held 5 cycles with resp_ready low.
    doTxn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 5, "bp load", rd, er);
    check("bp load rdata", rd, 64'h11223344AAAAAAAA);

    // Reset during WAIT of a store: the store is dropped and no response appears.
    doTxn(1'b1, 64'h8000_0020, 64'd0, 8'hFF, 0, "zero w4", rd, er);
    doTxn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 1, "pre-rst load", rd, er);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0020;
    req_wdata = 64'hFFFFFFFFFFFFFFFF; req_wmask = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst-wait req_ready", 64'(req_ready), 64'd1);
    check("rst-wait resp_rdata", resp_rdata, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst-wait no resp", 64'(resp_valid), 64'd0);
    end
    doTxn(1'b0, 64'h8000_0020, 64'd0, 8'h00, 0, "rst-wait load", rd, er);
    check("rst-wait load rdata", rd, 64'd0);

    // Reset on the very edge that would perform the store: still dropped.
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0020;
    req_wdata = 64'hFFFFFFFFFFFFFFFF; req_wmask = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (W) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst-resp no resp", 64'(resp_valid), 64'd0);
    doTxn(1'b0, 64'h8000_0020, 64'd0, 8'h00, 0, "rst-resp load", rd, er);
    check("rst-resp load rdata", rd, 64'd0);

    // Randomized traffic over 16 words against the byte-lane model.
    for (int k = 0; k < 16; k++) begin
      model[k] = {$urandom, $urandom};
      doTxn(1'b1, BASE + 64'(8 * k), model[k], 8'hFF, 0, "rand init", rd, er);
    end
    for (int n = 0; n < 80; n++) begin
      logic        wen;
      int          k;
      logic [63:0] addr, wdata;
      logic [7:0]  wmask;
      wen   = 1'($urandom_range(0, 1));
      k     = $urandom_range(0, 15);
      addr  = BASE + 64'(8 * k) + 64'($urandom_range(0, 7));
      wdata = {$urandom, $urandom};
      wmask = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      doTxn(wen, addr, wdata, wmask, $urandom_range(0, 3), $sformatf("rand%0d", n), rd, er);
      if (wen) begin
        model[k] = mergeBytes(model[k], wdata, wmask);
        check($sformatf("rand%0d store rdata", n), rd, 64'd0);
      end else begin
        check($sformatf("rand%0d load rdata", n), rd, model[k]);
      end
      check($sformatf("rand%0d err", n), 64'(er), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, mismatches);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
